// File: rtl/alu_apb_sequencer_if.sv
// Signal bundle for alu_apb_sequencer: the APB slave port plus the CSR-block
// and FIFO side-band. The sequencer uses the slave modport; its driver uses the master modport.
interface alu_apb_sequencer_if #(
    parameter int APB_BUS_SIZE   = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int FIFO_OUT_WIDTH = 32,
    parameter int CNT_WIDTH      = 4
);
    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [ADDR_WIDTH-1:0]     paddr;
    logic [APB_BUS_SIZE-1:0]   pwdata;
    logic [APB_BUS_SIZE-1:0]   prdata;
    logic                      pready;
    logic                      pslverr;
    logic                      start_bit;
    logic                      fifo_in_full;
    logic                      fifo_out_empty;
    logic [FIFO_OUT_WIDTH-1:0] final_result;
    logic [FIFO_OUT_WIDTH-1:0] fifo_out_status;
    logic                      en_ctrl;
    logic                      en_data0;
    logic                      en_data1;
    logic                      w_en_in;
    logic                      fifo_out_pop;
    logic                      r_en_out;
    logic [CNT_WIDTH-1:0]      pending_cnt;

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        input  start_bit, fifo_in_full, fifo_out_empty, final_result, fifo_out_status,
        output prdata, pready, pslverr,
        output en_ctrl, en_data0, en_data1, w_en_in, fifo_out_pop, r_en_out, pending_cnt
    );

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        output start_bit, fifo_in_full, fifo_out_empty, final_result, fifo_out_status,
        input  prdata, pready, pslverr,
        input  en_ctrl, en_data0, en_data1, w_en_in, fifo_out_pop, r_en_out, pending_cnt
    );
endinterface

// File: rtl/alu_apb_sequencer.sv
// APB slave sequencer for the ALU CSR block: register write enables, FIFO_IN
// launch, the two-cycle FIFO_OUT pop/capture read, and the in-flight op counter.
module alu_apb_sequencer #(
    parameter int APB_BUS_SIZE   = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int FIFO_OUT_WIDTH = 32,
    parameter int CNT_WIDTH      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_apb_sequencer_if.slave bus
);
    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_RD_HOLD = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL   = ADDR_WIDTH'(8'h00);
    localparam logic [ADDR_WIDTH-1:0] ADDR_DATA0  = ADDR_WIDTH'(8'h04);
    localparam logic [ADDR_WIDTH-1:0] ADDR_DATA1  = ADDR_WIDTH'(8'h08);
    localparam logic [ADDR_WIDTH-1:0] ADDR_RESULT = ADDR_WIDTH'(8'h0C);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS = ADDR_WIDTH'(8'h10);
    localparam logic [ADDR_WIDTH-1:0] ADDR_PEND   = ADDR_WIDTH'(8'h14);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX     = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE     = CNT_WIDTH'(1'b1);

    state_t                    r_state;
    logic                      r_w_en_in_q;
    logic [CNT_WIDTH-1:0]      r_pending_cnt;

    state_t                    w_next_state;
    logic                      w_access;
    logic                      w_hit_ctrl;
    logic                      w_hit_data0;
    logic                      w_hit_data1;
    logic                      w_hit_result;
    logic                      w_hit_status;
    logic                      w_hit_pend;
    logic                      w_addr_known;
    logic                      w_err;
    logic                      w_stall;
    logic                      w_launch;
    logic                      w_pready;
    logic                      w_pslverr;
    logic [APB_BUS_SIZE-1:0]   w_prdata;
    logic [APB_BUS_SIZE-1:0]   w_rd_data;
    logic                      w_en_ctrl;
    logic                      w_en_data0;
    logic                      w_en_data1;
    logic                      w_pop;
    logic                      w_r_en_out;
    logic [FIFO_OUT_WIDTH-1:0] w_final_result;
    logic [FIFO_OUT_WIDTH-1:0] w_status;

    assign w_access       = bus.psel & bus.penable;
    assign w_hit_ctrl     = (bus.paddr == ADDR_CTRL);
    assign w_hit_data0    = (bus.paddr == ADDR_DATA0);
    assign w_hit_data1    = (bus.paddr == ADDR_DATA1);
    assign w_hit_result   = (bus.paddr == ADDR_RESULT);
    assign w_hit_status   = (bus.paddr == ADDR_STATUS);
    assign w_hit_pend     = (bus.paddr == ADDR_PEND);
    assign w_addr_known   = w_hit_ctrl | w_hit_data0 | w_hit_data1 |
                            w_hit_result | w_hit_status | w_hit_pend;
    assign w_final_result = bus.final_result;
    assign w_status       = bus.fifo_out_status;

    // Unknown address, write to a read-only register, or RESULT read with nothing to pop.
    assign w_err = ~w_addr_known
                 | (bus.pwrite & (w_hit_result | w_hit_status | w_hit_pend))
                 | (~bus.pwrite & w_hit_result & bus.fifo_out_empty);

    // Writes hold off until the start bit has been consumed and its self-clear has landed.
    assign w_stall  = bus.start_bit | r_w_en_in_q;
    assign w_launch = rst_n & bus.start_bit & ~bus.fifo_in_full & ~r_w_en_in_q;

    // Read data mux for the single-cycle readable registers.
    always_comb begin
        w_rd_data = '0;
        if (w_hit_ctrl) begin
            w_rd_data = {{(APB_BUS_SIZE-1){1'b0}}, bus.start_bit};
        end else if (w_hit_status) begin
            w_rd_data = APB_BUS_SIZE'(w_status);
        end else if (w_hit_pend) begin
            w_rd_data = APB_BUS_SIZE'(r_pending_cnt);
        end else begin
            w_rd_data = '0;
        end
    end

    // APB response, strobes and next-state decode.
    always_comb begin
        w_next_state = r_state;
        w_pready     = 1'b0;
        w_pslverr    = 1'b0;
        w_prdata     = '0;
        w_en_ctrl    = 1'b0;
        w_en_data0   = 1'b0;
        w_en_data1   = 1'b0;
        w_pop        = 1'b0;
        w_r_en_out   = 1'b0;
        if (!rst_n) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_access) begin
                        w_next_state = ST_IDLE;
                    end else if (w_err) begin
                        w_pready  = 1'b1;
                        w_pslverr = 1'b1;
                    end else if (bus.pwrite) begin
                        if (w_stall) begin
                            w_pready = 1'b0;
                        end else begin
                            w_pready   = 1'b1;
                            w_en_ctrl  = w_hit_ctrl;
                            w_en_data0 = w_hit_data0;
                            w_en_data1 = w_hit_data1;
                        end
                    end else if (w_hit_result) begin
                        w_pop        = 1'b1;
                        w_r_en_out   = 1'b1;
                        w_next_state = ST_RD_HOLD;
                    end else begin
                        w_pready = 1'b1;
                        w_prdata = w_rd_data;
                    end
                end
                ST_RD_HOLD: begin
                    w_r_en_out   = 1'b1;
                    w_pready     = 1'b1;
                    w_prdata     = APB_BUS_SIZE'(w_final_result);
                    w_next_state = ST_IDLE;
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    // Main FSM state and launch history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_w_en_in_q <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_w_en_in_q <= w_launch;
        end
    end

    // Saturating in-flight operation counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending_cnt <= '0;
        end else if (w_launch && !w_pop && (r_pending_cnt != CNT_MAX)) begin
            r_pending_cnt <= r_pending_cnt + CNT_ONE;
        end else if (!w_launch && w_pop && (r_pending_cnt != '0)) begin
            r_pending_cnt <= r_pending_cnt - CNT_ONE;
        end else begin
            r_pending_cnt <= r_pending_cnt;
        end
    end

    assign bus.pready       = w_pready;
    assign bus.pslverr      = w_pslverr;
    assign bus.prdata       = w_prdata;
    assign bus.en_ctrl      = w_en_ctrl;
    assign bus.en_data0     = w_en_data0;
    assign bus.en_data1     = w_en_data1;
    assign bus.w_en_in      = w_launch;
    assign bus.fifo_out_pop = w_pop;
    assign bus.r_en_out     = w_r_en_out;
    assign bus.pending_cnt  = r_pending_cnt;
endmodule

// File: tb/tb_alu_apb_sequencer.sv
// Self-checking bench for alu_apb_sequencer: models the CSR start bit and a
// show-ahead FIFO_OUT, drives randomized APB traffic, and checks against expected counts.
module tb_alu_apb_sequencer;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int FW = 32;
    localparam int CW = 4;
    localparam int PEND_MAX = (1 << CW) - 1;
    localparam logic [7:0] A_CTRL   = 8'h00;
    localparam logic [7:0] A_DATA0  = 8'h04;
    localparam logic [7:0] A_DATA1  = 8'h08;
    localparam logic [7:0] A_RESULT = 8'h0C;
    localparam logic [7:0] A_STATUS = 8'h10;
    localparam logic [7:0] A_PEND   = 8'h14;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   exp_pend = 0;

    alu_apb_sequencer_if #(.APB_BUS_SIZE(DW), .ADDR_WIDTH(AW), .FIFO_OUT_WIDTH(FW), .CNT_WIDTH(CW)) bus ();

    alu_apb_sequencer #(.APB_BUS_SIZE(DW), .ADDR_WIDTH(AW), .FIFO_OUT_WIDTH(FW), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Register-block start bit: set by a CTRL write, self-cleared by the launch.
    logic start_q;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)            start_q <= 1'b0;
        else if (bus.en_ctrl)  start_q <= bus.pwdata[0];
        else if (bus.w_en_in)  start_q <= 1'b0;
    end
    assign bus.start_bit = start_q;

    // Show-ahead FIFO_OUT and RESULT register (zero outside the capture window).
    logic [31:0] fo_mem [0:15];
    int          fo_rd = 0;
    int          fo_wr = 0;
    logic [31:0] res_q = 32'h0;
    always @(posedge clk) begin
        if (rst_n && bus.fifo_out_pop) begin
            res_q <= fo_mem[fo_rd[3:0]];
            fo_rd <= fo_rd + 1;
        end
    end
    assign bus.fifo_out_empty = (fo_rd == fo_wr);
    assign bus.final_result   = bus.r_en_out ? res_q : 32'h0;

    // Event monitor for push/pop timing.
    int push_cnt = 0, pop_cnt = 0, last_push_cyc = -1, last_pop_cyc = -1;
    always @(negedge clk) begin
        if (rst_n && bus.w_en_in)      begin push_cnt <= push_cnt + 1; last_push_cyc <= cyc; end
        if (rst_n && bus.fifo_out_pop) begin pop_cnt  <= pop_cnt + 1;  last_pop_cyc  <= cyc; end
    end

    // Results of the most recent transfer.
    int          t_waits, t_pops, t_ren, t_done_cyc;
    logic [2:0]  t_en;
    logic        t_err, t_bad_en;
    logic [31:0] t_data;

    task automatic fo_push(input logic [31:0] v);
        fo_mem[fo_wr[3:0]] = v;
        fo_wr = fo_wr + 1;
    endtask

    task automatic idle();
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One APB transfer; starts and ends 1 time unit after a rising edge.
    task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] data, input bit setup);
        bit done;
        t_waits = 0; t_pops = 0; t_ren = 0; t_en = 3'b000; t_err = 1'b0; t_bad_en = 1'b0;
        t_data = 32'h0; t_done_cyc = -1; done = 1'b0;
        bus.psel = 1'b1; bus.pwrite = wr; bus.paddr = addr; bus.pwdata = data;
        if (setup) begin
            bus.penable = 1'b0;
            tick(1);
        end
        bus.penable = 1'b1;
        while (!done && t_waits <= 50) begin
            @(negedge clk);
            if (bus.fifo_out_pop) t_pops++;
            if (bus.r_en_out)     t_ren++;
            if (bus.pready) begin
                t_en = {bus.en_ctrl, bus.en_data0, bus.en_data1};
                t_err = bus.pslverr; t_data = bus.prdata; t_done_cyc = cyc;
                done = 1'b1;
            end else begin
                if (bus.en_ctrl | bus.en_data0 | bus.en_data1) t_bad_en = 1'b1;
                t_waits++;
            end
            tick(1);
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL xfer_timeout addr=%0h: no pready after %0d cycles", addr, t_waits);
        end
    endtask

    task automatic check_pend_read(input string name);
        apb_xfer(1'b0, A_PEND, 32'h0, 1'b1);
        idle();
        checks++;
        if (t_data !== 32'(exp_pend) || t_err !== 1'b0 || t_waits !== 0) begin
            errors++;
            $display("FAIL %s: pend=%0d err=%0b waits=%0d, expected pend=%0d err=0 waits=0",
                     name, t_data, t_err, t_waits, exp_pend);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.psel = 1'b1; bus.penable = 1'b1; bus.pwrite = 1'b1; bus.paddr = A_CTRL; bus.pwdata = 32'h1;
        tick(2);
        @(negedge clk);
        checks++;
        if ({bus.pready, bus.pslverr, bus.en_ctrl, bus.en_data0, bus.en_data1,
             bus.w_en_in, bus.fifo_out_pop, bus.r_en_out} !== 8'h00 || bus.prdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: strobes=%b prdata=%0h, expected all 0",
                     {bus.pready, bus.pslverr, bus.en_ctrl, bus.en_data0, bus.en_data1,
                      bus.w_en_in, bus.fifo_out_pop, bus.r_en_out}, bus.prdata);
        end
        checks++;
        if (bus.pending_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_pending: got %0d expected 0", bus.pending_cnt);
        end
        tick(1);
        idle();
        rst_n = 1'b1;
        exp_pend = 0;
        tick(1);
        check_pend_read("reset_pend_read");
    endtask

    task automatic test_basic_launch();
        logic [31:0] d;
        int push0, ctrl_cyc;
        d = $urandom;
        apb_xfer(1'b1, A_DATA0, d, 1'b1);
        checks++;
        if (t_en !== 3'b010 || t_waits !== 0 || t_err !== 1'b0) begin
            errors++; $display("FAIL write_data0: en=%b waits=%0d err=%0b, expected 010/0/0", t_en, t_waits, t_err);
        end
        d = $urandom;
        apb_xfer(1'b1, A_DATA1, d, 1'b1);
        checks++;
        if (t_en !== 3'b001 || t_waits !== 0 || t_err !== 1'b0) begin
            errors++; $display("FAIL write_data1: en=%b waits=%0d err=%0b, expected 001/0/0", t_en, t_waits, t_err);
        end
        push0 = push_cnt;
        d = $urandom; d[0] = 1'b1;
        apb_xfer(1'b1, A_CTRL, d, 1'b1);
        ctrl_cyc = t_done_cyc;
        checks++;
        if (t_en !== 3'b100 || t_waits !== 0) begin
            errors++; $display("FAIL write_ctrl: en=%b waits=%0d, expected 100/0", t_en, t_waits);
        end
        // Back-to-back CTRL write with bit 0 clear: must stall two cycles and launch nothing.
        d = $urandom; d[0] = 1'b0;
        apb_xfer(1'b1, A_CTRL, d, 1'b0);
        idle();
        checks++;
        if (t_waits !== 2 || t_bad_en !== 1'b0 || t_en !== 3'b100) begin
            errors++; $display("FAIL ctrl_stall: waits=%0d bad_en=%0b en=%b, expected 2/0/100", t_waits, t_bad_en, t_en);
        end
        tick(3);
        checks++;
        if (push_cnt - push0 !== 1 || last_push_cyc !== ctrl_cyc + 1) begin
            errors++; $display("FAIL launch_timing: pushes=%0d at cyc %0d, expected 1 at cyc %0d",
                               push_cnt - push0, last_push_cyc, ctrl_cyc + 1);
        end
        if (exp_pend < PEND_MAX) exp_pend++;
        check_pend_read("launch_pend");
        apb_xfer(1'b0, A_CTRL, 32'h0, 1'b1);
        idle();
        checks++;
        if (t_data !== 32'h0) begin
            errors++; $display("FAIL ctrl_read_clear: got %0h expected 0", t_data);
        end
    endtask

    task automatic test_fifo_in_full();
        logic [31:0] d;
        int push0, drop_cyc, pushed_early;
        bus.fifo_in_full = 1'b1;
        push0 = push_cnt;
        d = $urandom; d[0] = 1'b1;
        apb_xfer(1'b1, A_CTRL, d, 1'b1);
        apb_xfer(1'b0, A_CTRL, 32'h0, 1'b1);
        checks++;
        if (t_data !== 32'h1) begin
            errors++; $display("FAIL full_start_held: ctrl read %0h expected 1", t_data);
        end
        drop_cyc = 0; pushed_early = 0;
        fork
            apb_xfer(1'b1, A_DATA0, $urandom, 1'b1);
            begin
                tick(5);
                pushed_early = push_cnt - push0;
                bus.fifo_in_full = 1'b0;
                drop_cyc = cyc;
            end
        join
        idle();
        tick(2);
        checks++;
        if (pushed_early !== 0) begin
            errors++; $display("FAIL full_no_push: %0d pushes while full, expected 0", pushed_early);
        end
        checks++;
        if (push_cnt - push0 !== 1 || last_push_cyc !== drop_cyc) begin
            errors++; $display("FAIL full_release_push: pushes=%0d at cyc %0d, expected 1 at cyc %0d",
                               push_cnt - push0, last_push_cyc, drop_cyc);
        end
        checks++;
        if (t_done_cyc !== drop_cyc + 2 || t_en !== 3'b010 || t_bad_en !== 1'b0) begin
            errors++; $display("FAIL full_stall_release: done cyc %0d en=%b bad_en=%0b, expected cyc %0d en=010 bad_en=0",
                               t_done_cyc, t_en, t_bad_en, drop_cyc + 2);
        end
        if (exp_pend < PEND_MAX) exp_pend++;
        check_pend_read("full_pend");
    endtask

    task automatic test_result_read();
        logic [31:0] vals [0:2];
        for (int i = 0; i < 3; i++) begin
            vals[i] = $urandom;
            fo_push(vals[i]);
        end
        for (int i = 0; i < 3; i++) begin
            apb_xfer(1'b0, A_RESULT, 32'h0, 1'b1);
            idle();
            checks++;
            if (t_data !== vals[i] || t_waits !== 1 || t_pops !== 1 || t_ren !== 2 || t_err !== 1'b0) begin
                errors++; $display("FAIL result_read%0d: data=%0h waits=%0d pops=%0d ren=%0d err=%0b, expected %0h/1/1/2/0",
                                   i, t_data, t_waits, t_pops, t_ren, t_err, vals[i]);
            end
            if (exp_pend > 0) exp_pend--;
            check_pend_read("result_pend");
        end
        apb_xfer(1'b0, A_RESULT, 32'h0, 1'b1);
        idle();
        checks++;
        if (t_err !== 1'b1 || t_data !== 32'h0 || t_pops !== 0 || t_waits !== 0) begin
            errors++; $display("FAIL result_empty: err=%0b data=%0h pops=%0d waits=%0d, expected 1/0/0/0",
                               t_err, t_data, t_pops, t_waits);
        end
    endtask

    task automatic test_errors();
        logic [7:0] ro [0:2];
        logic [7:0] a;
        logic [31:0] st;
        int push0, pop0;
        ro[0] = A_RESULT; ro[1] = A_STATUS; ro[2] = A_PEND;
        push0 = push_cnt; pop0 = pop_cnt;
        fo_push($urandom);
        for (int i = 0; i < 3; i++) begin
            apb_xfer(1'b1, ro[i], $urandom, 1'b1);
            idle();
            checks++;
            if (t_err !== 1'b1 || t_en !== 3'b000 || t_waits !== 0 || t_pops !== 0) begin
                errors++; $display("FAIL ro_write %0h: err=%0b en=%b waits=%0d pops=%0d, expected 1/000/0/0",
                                   ro[i], t_err, t_en, t_waits, t_pops);
            end
        end
        for (int i = 0; i < 4; i++) begin
            a = 8'($urandom_range(21, 255));
            apb_xfer(i[0], a, $urandom, 1'b1);
            idle();
            checks++;
            if (t_err !== 1'b1 || t_data !== 32'h0 || t_en !== 3'b000 || t_waits !== 0) begin
                errors++; $display("FAIL bad_addr %0h: err=%0b data=%0h en=%b waits=%0d, expected 1/0/000/0",
                                   a, t_err, t_data, t_en, t_waits);
            end
        end
        st = $urandom;
        bus.fifo_out_status = st;
        apb_xfer(1'b0, A_STATUS, 32'h0, 1'b1);
        idle();
        checks++;
        if (t_data !== st || t_err !== 1'b0) begin
            errors++; $display("FAIL status_read: got %0h err=%0b expected %0h err=0", t_data, t_err, st);
        end
        apb_xfer(1'b0, A_DATA1, 32'h0, 1'b1);
        idle();
        checks++;
        if (t_data !== 32'h0 || t_err !== 1'b0) begin
            errors++; $display("FAIL data1_read: got %0h err=%0b expected 0 err=0", t_data, t_err);
        end
        checks++;
        if (push_cnt !== push0 || pop_cnt !== pop0) begin
            errors++; $display("FAIL err_side_effects: pushes=%0d pops=%0d, expected 0/0",
                               push_cnt - push0, pop_cnt - pop0);
        end
        check_pend_read("err_pend");
        apb_xfer(1'b0, A_RESULT, 32'h0, 1'b1);
        idle();
    endtask

    task automatic test_simultaneous();
        logic [31:0] v;
        logic [31:0] d;
        apb_xfer(1'b1, A_CTRL, 32'h1, 1'b1);
        idle();
        tick(3);
        if (exp_pend < PEND_MAX) exp_pend++;
        v = $urandom;
        fo_push(v);
        d = $urandom; d[0] = 1'b1;
        apb_xfer(1'b1, A_CTRL, d, 1'b1);
        apb_xfer(1'b0, A_RESULT, 32'h0, 1'b0);
        idle();
        tick(2);
        checks++;
        if (last_push_cyc !== last_pop_cyc || t_data !== v) begin
            errors++; $display("FAIL simul_events: push cyc %0d pop cyc %0d data %0h, expected same cycle and data %0h",
                               last_push_cyc, last_pop_cyc, t_data, v);
        end
        check_pend_read("simul_pend");
    endtask

    task automatic test_saturation();
        int push0;
        logic [31:0] v;
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        exp_pend = 0;
        push0 = push_cnt;
        for (int i = 0; i < 16; i++) begin
            apb_xfer(1'b1, A_CTRL, 32'h1, 1'b1);
            if (exp_pend < PEND_MAX) exp_pend++;
        end
        idle();
        tick(3);
        checks++;
        if (push_cnt - push0 !== 16) begin
            errors++; $display("FAIL sat_pushes: got %0d expected 16", push_cnt - push0);
        end
        check_pend_read("sat_pend");
        v = $urandom;
        fo_push(v);
        apb_xfer(1'b0, A_RESULT, 32'h0, 1'b1);
        idle();
        if (exp_pend > 0) exp_pend--;
        check_pend_read("sat_pop_pend");
    endtask

    task automatic test_reset_mid_read();
        fo_push($urandom);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = A_RESULT;
        tick(1);
        bus.penable = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.fifo_out_pop !== 1'b1 || bus.r_en_out !== 1'b1 || bus.pready !== 1'b0) begin
            errors++; $display("FAIL midrd_a1: pop=%0b ren=%0b pready=%0b, expected 1/1/0",
                               bus.fifo_out_pop, bus.r_en_out, bus.pready);
        end
        tick(1);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.pready !== 1'b0 || bus.r_en_out !== 1'b0 || bus.prdata !== 32'h0 || bus.pending_cnt !== 4'd0) begin
            errors++; $display("FAIL midrd_reset: pready=%0b ren=%0b prdata=%0h pend=%0d, expected all 0",
                               bus.pready, bus.r_en_out, bus.prdata, bus.pending_cnt);
        end
        tick(1);
        idle();
        rst_n = 1'b1;
        exp_pend = 0;
        tick(1);
        check_pend_read("midrd_idle_pend");
        apb_xfer(1'b0, A_RESULT, 32'h0, 1'b1);
        idle();
        checks++;
        if (t_err !== 1'b1 || t_pops !== 0) begin
            errors++; $display("FAIL midrd_entry_lost: err=%0b pops=%0d, expected 1/0", t_err, t_pops);
        end
    endtask

    initial begin
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        bus.paddr = 8'h00; bus.pwdata = 32'h0;
        bus.fifo_in_full = 1'b0; bus.fifo_out_status = 32'h0;
        test_reset();
        test_basic_launch();
        test_fifo_in_full();
        test_result_read();
        test_errors();
        test_simultaneous();
        test_saturation();
        test_reset_mid_read();
        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
